// File: rtl/axis_pkt_checker.sv
// AXI-Stream packet sink: decodes the flow ID from the header beat, checks
// length, tkeep, payload pattern and per-flow sequence order, and keeps
// packet/error/per-flow counters plus a byte-throughput snapshot per interval.
`timescale 1ns/1ps
module axis_pkt_checker #(
  parameter int DATA_WIDTH   = 512,
  parameter int KEEP_WIDTH   = DATA_WIDTH/8,
  parameter int PKT_BEATS    = 23,
  parameter int FLOW_NUM     = 4,
  parameter int FLOW_ID_BYTE = 35,
  parameter int INTERVAL     = 4096,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [CNT_WIDTH-1:0]          pkt_count,
  output logic [CNT_WIDTH-1:0]          err_count,
  output logic [FLOW_NUM*CNT_WIDTH-1:0] flow_pkt_count,
  output logic [2:0]                    last_err_code,
  output logic                          err_flag,
  output logic [CNT_WIDTH-1:0]          interval_bytes,
  output logic                          interval_valid
);

  localparam int IDX_W = $clog2(PKT_BEATS + 1);
  localparam int FID_W = (FLOW_NUM > 1) ? $clog2(FLOW_NUM) : 1;
  localparam int CYC_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_LEN  = 3'd1;
  localparam logic [2:0] ERR_KEEP = 3'd2;
  localparam logic [2:0] ERR_FLOW = 3'd3;
  localparam logic [2:0] ERR_SEQ  = 3'd4;
  localparam logic [2:0] ERR_DATA = 3'd5;

  typedef enum logic [1:0] {HEAD = 2'd0, BODY = 2'd1, DRAIN = 2'd2} state_t;

  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] i);
    return (i >= IDX_W'(PKT_BEATS)) ? i : i + IDX_W'(1);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [KEEP_WIDTH-1:0] k);
    logic [CNT_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) c = c + CNT_WIDTH'(k[i]);
    return c;
  endfunction

  function automatic logic [2:0] err_prio(input logic len, input logic keep,
                                          input logic flow, input logic seq,
                                          input logic data);
    if (len)  return ERR_LEN;
    if (keep) return ERR_KEEP;
    if (flow) return ERR_FLOW;
    if (seq)  return ERR_SEQ;
    if (data) return ERR_DATA;
    return ERR_NONE;
  endfunction

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [2:0]           pkt_err, pkt_err_nxt;
  logic [7:0]           fid;
  logic [63:0]          base;
  logic [63:0]          last_base [FLOW_NUM];
  logic [FLOW_NUM-1:0]  seen;
  logic [CNT_WIDTH-1:0] flow_cnt [FLOW_NUM];
  logic [CYC_W-1:0]     cyc;
  logic [CNT_WIDTH-1:0] acc;

  logic                 accept, close;
  logic [63:0]          w, cur_base;
  logic [7:0]           hdr_fid, cur_fid;
  logic [FID_W-1:0]     fid_idx, cur_fid_idx;
  logic                 cur_fid_ok;
  logic                 e_len, e_keep, e_flow, e_seq, e_data;
  logic [2:0]           beat_code, pkt_code;
  logic [CNT_WIDTH-1:0] beat_bytes;
  logic                 unused_tdata;

  assign accept       = s_axis_tvalid && s_axis_tready;
  assign w            = s_axis_tdata[63:0];
  assign hdr_fid      = s_axis_tdata[FLOW_ID_BYTE*8 +: 8];
  assign fid_idx      = fid[FID_W-1:0];
  assign cur_fid_idx  = cur_fid[FID_W-1:0];
  assign cur_fid_ok   = cur_fid < 8'(FLOW_NUM);
  assign beat_bytes   = accept ? popcount(s_axis_tkeep) : '0;
  assign unused_tdata = ^s_axis_tdata;

  for (genvar g = 0; g < FLOW_NUM; g++) begin : g_flow_out
    assign flow_pkt_count[g*CNT_WIDTH +: CNT_WIDTH] = flow_cnt[g];
  end

  // Next-state logic: beat classification, per-beat error detection, packet close.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    pkt_err_nxt = pkt_err;
    cur_fid     = fid;
    cur_base    = base;
    close       = 1'b0;
    e_len       = 1'b0;
    e_keep      = 1'b0;
    e_flow      = 1'b0;
    e_seq       = 1'b0;
    e_data      = 1'b0;
    beat_code   = ERR_NONE;
    pkt_code    = ERR_NONE;
    if (accept) begin
      e_keep = !(&s_axis_tkeep);
      case (state)
        HEAD: begin
          cur_fid = hdr_fid;
          e_flow  = hdr_fid >= 8'(FLOW_NUM);
          if (s_axis_tlast) begin
            e_len = 1'b1;
            close = 1'b1;
          end else begin
            state_nxt = BODY;
            idx_nxt   = IDX_W'(1);
          end
        end
        BODY: begin
          if (idx == IDX_W'(1)) begin
            cur_base = w - 64'd1;
            e_seq    = (fid < 8'(FLOW_NUM)) && seen[fid_idx] &&
                       !(cur_base > last_base[fid_idx]);
          end else begin
            e_data = w != base + 64'(idx);
          end
          if (s_axis_tlast) begin
            e_len     = idx < IDX_W'(PKT_BEATS - 1);
            close     = 1'b1;
            state_nxt = HEAD;
            idx_nxt   = '0;
          end else if (idx == IDX_W'(PKT_BEATS - 1)) begin
            e_len     = 1'b1;
            state_nxt = DRAIN;
            idx_nxt   = sat_inc(idx);
          end else begin
            idx_nxt = sat_inc(idx);
          end
        end
        DRAIN: begin
          if (s_axis_tlast) begin
            close     = 1'b1;
            state_nxt = HEAD;
            idx_nxt   = '0;
          end else begin
            idx_nxt = sat_inc(idx);
          end
        end
        default: state_nxt = HEAD;
      endcase
      beat_code   = err_prio(e_len, e_keep, e_flow, e_seq, e_data);
      pkt_code    = (state != HEAD && pkt_err != ERR_NONE) ? pkt_err : beat_code;
      pkt_err_nxt = close ? ERR_NONE : pkt_code;
    end
  end

  // Control state register: FSM state, beat index, sticky packet error, tready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HEAD;
      idx           <= '0;
      pkt_err       <= ERR_NONE;
      s_axis_tready <= 1'b0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      pkt_err       <= pkt_err_nxt;
      s_axis_tready <= 1'b1;
    end
  end

  // Packet context: latched flow ID, sequence base, and per-flow last base.
  always_ff @(posedge clk) begin
    if (accept && state == HEAD) fid <= hdr_fid;
    if (accept && state == BODY && idx == IDX_W'(1)) base <= cur_base;
    if (accept && close && state != HEAD && cur_fid_ok) last_base[cur_fid_idx] <= cur_base;
  end

  // Packet statistics, updated on the tlast handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count     <= '0;
      err_count     <= '0;
      last_err_code <= ERR_NONE;
      err_flag      <= 1'b0;
      seen          <= '0;
      for (int f = 0; f < FLOW_NUM; f++) flow_cnt[f] <= '0;
    end else if (accept && close) begin
      pkt_count <= pkt_count + CNT_WIDTH'(1);
      if (cur_fid_ok) begin
        flow_cnt[cur_fid_idx] <= flow_cnt[cur_fid_idx] + CNT_WIDTH'(1);
        if (state != HEAD) seen[cur_fid_idx] <= 1'b1;
      end
      if (pkt_code != ERR_NONE) begin
        err_count     <= err_count + CNT_WIDTH'(1);
        last_err_code <= pkt_code;
        err_flag      <= 1'b1;
      end
    end
  end

  // Throughput: accumulate accepted bytes and publish once per interval.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc            <= '0;
      acc            <= '0;
      interval_bytes <= '0;
      interval_valid <= 1'b0;
    end else if (cyc == CYC_W'(INTERVAL - 1)) begin
      cyc            <= '0;
      acc            <= '0;
      interval_bytes <= acc + beat_bytes;
      interval_valid <= 1'b1;
    end else begin
      cyc            <= cyc + CYC_W'(1);
      acc            <= acc + beat_bytes;
      interval_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_pkt_checker.sv
// Bench for axis_pkt_checker: directed packet stimulus, a packet-level
// reference model compared every cycle, plus hand-computed literal checks.
`timescale 1ns/1ps
module tb_axis_pkt_checker;
  localparam int DATA_WIDTH   = 512;
  localparam int KEEP_WIDTH   = DATA_WIDTH/8;
  localparam int PKT_BEATS    = 23;
  localparam int FLOW_NUM     = 4;
  localparam int FLOW_ID_BYTE = 35;
  localparam int INTERVAL     = 4096;
  localparam int CNT_WIDTH    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DATA_WIDTH-1:0]         s_axis_tdata = '0;
  logic [KEEP_WIDTH-1:0]         s_axis_tkeep = '0;
  logic                          s_axis_tvalid = 1'b0;
  logic                          s_axis_tready;
  logic                          s_axis_tlast = 1'b0;
  logic [CNT_WIDTH-1:0]          pkt_count, err_count, interval_bytes;
  logic [FLOW_NUM*CNT_WIDTH-1:0] flow_pkt_count;
  logic [2:0]                    last_err_code;
  logic                          err_flag, interval_valid;

  always #5 clk = ~clk;

  axis_pkt_checker #(
    .DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH), .PKT_BEATS(PKT_BEATS),
    .FLOW_NUM(FLOW_NUM), .FLOW_ID_BYTE(FLOW_ID_BYTE), .INTERVAL(INTERVAL),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .pkt_count(pkt_count), .err_count(err_count), .flow_pkt_count(flow_pkt_count),
    .last_err_code(last_err_code), .err_flag(err_flag),
    .interval_bytes(interval_bytes), .interval_valid(interval_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (packet level) ----------------
  bit          started = 1'b0;
  bit          m_tready;
  int unsigned m_pkt, m_err, m_ibytes, m_acc;
  int unsigned m_flow [FLOW_NUM];
  logic [2:0]  m_code;
  bit          m_flag, m_ivalid;
  int          m_cyc;
  bit          m_seen  [FLOW_NUM];
  logic [63:0] m_lastb [FLOW_NUM];
  logic [63:0] m_w     [64];
  bit          m_kok   [64];
  int          m_n, m_fid;

  // Judge a whole finished packet: walk its beats, take the first beat with
  // any error, and on that beat report the highest-priority one.
  task automatic close_pkt();
    logic [2:0]  code;
    logic [63:0] b;
    bit len, keep, flow, seq, data;
    code = 3'd0;
    b = m_w[1] - 64'd1;
    for (int k = 0; k < m_n && k < 64; k++) begin
      len  = (k == m_n - 1 && m_n < PKT_BEATS) || (k == PKT_BEATS - 1 && m_n > PKT_BEATS);
      keep = !m_kok[k];
      flow = (k == 0) && (m_fid >= FLOW_NUM);
      seq  = (k == 1) && (m_fid < FLOW_NUM) && m_seen[m_fid] && !(b > m_lastb[m_fid]);
      data = (k >= 2) && (k <= PKT_BEATS - 1) && (m_w[k] != b + 64'(k));
      if (code == 3'd0) begin
        if (len) code = 3'd1;
        else if (keep) code = 3'd2;
        else if (flow) code = 3'd3;
        else if (seq) code = 3'd4;
        else if (data) code = 3'd5;
      end
    end
    m_pkt++;
    if (m_fid < FLOW_NUM) begin
      m_flow[m_fid]++;
      if (m_n >= 2) begin
        m_lastb[m_fid] = b;
        m_seen[m_fid]  = 1'b1;
      end
    end
    if (code != 3'd0) begin
      m_err++;
      m_code = code;
      m_flag = 1'b1;
    end
  endtask

  always @(posedge clk) begin : model
    int bytes;
    if (rst) begin
      started = 1'b1;
      m_tready = 1'b0; m_pkt = 0; m_err = 0; m_code = 3'd0; m_flag = 1'b0;
      m_ibytes = 0; m_ivalid = 1'b0; m_cyc = 0; m_acc = 0; m_n = 0; m_fid = 0;
      for (int f = 0; f < FLOW_NUM; f++) begin
        m_flow[f] = 0; m_seen[f] = 1'b0;
      end
    end else begin
      bytes = 0;
      if (s_axis_tvalid && m_tready) begin
        bytes = $countones(s_axis_tkeep);
        if (m_n == 0) m_fid = int'(s_axis_tdata[FLOW_ID_BYTE*8 +: 8]);
        if (m_n < 64) begin
          m_w[m_n]   = s_axis_tdata[63:0];
          m_kok[m_n] = (s_axis_tkeep == '1);
        end
        m_n++;
        if (s_axis_tlast) begin
          close_pkt();
          m_n = 0;
        end
      end
      if (m_cyc == INTERVAL - 1) begin
        m_ibytes = m_acc + bytes; m_acc = 0; m_ivalid = 1'b1; m_cyc = 0;
      end else begin
        m_acc = m_acc + bytes; m_ivalid = 1'b0; m_cyc++;
      end
      m_tready = 1'b1;
    end
  end

  // Compare every output against the model on every cycle.
  always @(negedge clk) begin
    if (started) begin
      chk("tready", 64'(s_axis_tready), 64'(m_tready));
      chk("pkt_count", 64'(pkt_count), 64'(m_pkt));
      chk("err_count", 64'(err_count), 64'(m_err));
      chk("last_err_code", 64'(last_err_code), 64'(m_code));
      chk("err_flag", 64'(err_flag), 64'(m_flag));
      chk("interval_bytes", 64'(interval_bytes), 64'(m_ibytes));
      chk("interval_valid", 64'(interval_valid), 64'(m_ivalid));
      for (int f = 0; f < FLOW_NUM; f++)
        chk($sformatf("flow_cnt%0d", f), 64'(flow_pkt_count[f*CNT_WIDTH +: CNT_WIDTH]), 64'(m_flow[f]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic put_beat(input int fid, input logic [63:0] w, input bit kbad, input bit last);
    s_axis_tdata = '0;
    s_axis_tdata[63:0] = w;
    s_axis_tdata[FLOW_ID_BYTE*8 +: 8] = 8'(fid);
    s_axis_tkeep  = kbad ? {4'h0, {(KEEP_WIDTH-4){1'b1}}} : '1;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
  endtask

  task automatic send_pkt(input int fid, input logic [63:0] base, input int n,
                          input int bad_data, input int bad_keep, input int gap);
    logic [63:0] w;
    for (int k = 0; k < n; k++) begin
      if (k == gap) begin
        s_axis_tvalid = 1'b0;
        @(negedge clk);
      end
      w = (k == 0) ? 64'hDEAD_BEEF_0000_0000 : base + 64'(k) + ((k == bad_data) ? 64'd1 : 64'd0);
      put_beat(fid, w, k == bad_keep, k == n - 1);
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [63:0] flow_out(input int f);
    return 64'(flow_pkt_count[f*CNT_WIDTH +: CNT_WIDTH]);
  endfunction

  int good_flows [10] = '{0, 1, 2, 0, 1, 1, 0, 1, 2, 1};

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_tready", 64'(s_axis_tready), 64'd0);
    chk("reset_pkt", 64'(pkt_count), 64'd0);
    chk("reset_ivalid", 64'(interval_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("tready_after_reset", 64'(s_axis_tready), 64'd1);

    // good stream: beat k of packet n carries k+n
    for (int n = 0; n < 10; n++) send_pkt(good_flows[n], 64'(n), PKT_BEATS, -1, -1, -1);
    chk("good_pkt", 64'(pkt_count), 64'd10);
    chk("good_f0", flow_out(0), 64'd3);
    chk("good_f1", flow_out(1), 64'd5);
    chk("good_f2", flow_out(2), 64'd2);
    chk("good_err", 64'(err_count), 64'd0);
    chk("good_flag", 64'(err_flag), 64'd0);

    // short then long packet, then a good one after drain
    send_pkt(0, 64'd20, 11, -1, -1, -1);
    send_pkt(0, 64'd21, 25, -1, -1, -1);
    chk("len_err", 64'(err_count), 64'd2);
    chk("len_code", 64'(last_err_code), 64'd1);
    send_pkt(0, 64'd22, PKT_BEATS, -1, -1, -1);
    chk("drain_recover_pkt", 64'(pkt_count), 64'd13);
    chk("drain_recover_err", 64'(err_count), 64'd2);
    chk("drain_recover_f0", flow_out(0), 64'd6);

    // bad content
    send_pkt(1, 64'd30, PKT_BEATS, 5, -1, -1);
    chk("data_code", 64'(last_err_code), 64'd5);
    send_pkt(1, 64'd31, PKT_BEATS, -1, 7, -1);
    chk("keep_code", 64'(last_err_code), 64'd2);
    send_pkt(7, 64'd32, PKT_BEATS, -1, -1, -1);
    chk("flow_code", 64'(last_err_code), 64'd3);
    chk("flow_f0", flow_out(0), 64'd6);
    chk("flow_f1", flow_out(1), 64'd7);
    chk("flow_f2", flow_out(2), 64'd2);
    chk("flow_f3", flow_out(3), 64'd0);
    send_pkt(1, 64'd33, PKT_BEATS, 9, 9, -1);
    chk("keep_data_prio", 64'(last_err_code), 64'd2);
    chk("bad_err", 64'(err_count), 64'd6);
    send_pkt(2, 64'd40, PKT_BEATS, -1, -1, 12);
    chk("gap_err", 64'(err_count), 64'd6);
    chk("gap_f2", flow_out(2), 64'd3);

    // per-flow sequence
    do_reset();
    send_pkt(1, 64'd5, PKT_BEATS, -1, -1, -1);
    chk("seq_first", 64'(err_count), 64'd0);
    send_pkt(1, 64'd3, PKT_BEATS, -1, -1, -1);
    chk("seq_code", 64'(last_err_code), 64'd4);
    send_pkt(2, 64'd3, PKT_BEATS, -1, -1, -1);
    chk("seq_other_flow", 64'(err_count), 64'd1);
    chk("seq_pkt", 64'(pkt_count), 64'd3);

    // reset mid-packet at idx 12
    for (int k = 0; k < 12; k++) begin
      put_beat(1, (k == 0) ? 64'hDEAD_BEEF_0000_0000 : 64'd10 + 64'(k), 1'b0, 1'b0);
      @(negedge clk);
    end
    put_beat(1, 64'd22, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    chk("midrst_tready", 64'(s_axis_tready), 64'd0);
    chk("midrst_pkt", 64'(pkt_count), 64'd0);
    chk("midrst_err", 64'(err_count), 64'd0);
    chk("midrst_flow", 64'(flow_pkt_count), 64'd0);
    chk("midrst_code", 64'(last_err_code), 64'd0);
    chk("midrst_flag", 64'(err_flag), 64'd0);
    chk("midrst_ibytes", 64'(interval_bytes), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int f = 0; f < FLOW_NUM; f++) send_pkt(f, 64'd1, PKT_BEATS, -1, -1, -1);
    chk("post_rst_pkt", 64'(pkt_count), 64'd4);
    chk("post_rst_err", 64'(err_count), 64'd0);
    chk("post_rst_flag", 64'(err_flag), 64'd0);
    chk("post_rst_f1", flow_out(1), 64'd1);

    // throughput with a continuous stream
    do_reset();
    fork
      begin
        for (int p = 0; p < 360; p++) send_pkt(p % 4, 64'd100 + 64'(p), PKT_BEATS, -1, -1, -1);
      end
      begin
        int n, t1, t2;
        logic [CNT_WIDTH-1:0] b1, b2;
        n = 1; t1 = 0; t2 = 0; b1 = '0; b2 = '0;
        while (n < 9000 && t2 == 0) begin
          @(negedge clk);
          n++;
          if (interval_valid) begin
            if (t1 == 0) begin t1 = n; b1 = interval_bytes; end
            else begin t2 = n; b2 = interval_bytes; end
          end
        end
        chk("ivalid_first_cycle", 64'(t1), 64'd4096);
        chk("ivalid_period", 64'(t2 - t1), 64'd4096);
        chk("ibytes_first", 64'(b1), 64'd262080);
        chk("ibytes_full", 64'(b2), 64'd262144);
      end
    join

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_pkt_checker.md
# axis_pkt_checker

Synthesizable AXI-Stream packet sink and checker on the panic `m_rx_axis` output, the far end of the traffic-generator stream. It consumes 512-bit packets, decodes the flow ID from the header beat and checks each packet's length, tkeep, payload pattern and per-flow sequence order. It keeps packet, error and per-flow counters and publishes a byte-throughput snapshot every logging interval.

## Interface
- DATA_WIDTH, 512: stream data width in bits.
- KEEP_WIDTH, DATA_WIDTH/8: tkeep width.
- PKT_BEATS, 23: expected beats per packet, header beat included.
- FLOW_NUM, 4: number of valid flow IDs, 0..FLOW_NUM-1.
- FLOW_ID_BYTE, 35: byte lane in the header beat holding the 8-bit flow ID.
- INTERVAL, 4096: logging interval in clk cycles.
- CNT_WIDTH, 32: width of all statistics counters.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- s_axis_tdata  in  DATA_WIDTH  packet data.
- s_axis_tkeep  in  KEEP_WIDTH  byte enables.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  registered. 0 during reset, then 1 from the first cycle after rst deasserts.
- s_axis_tlast  in  1  last beat of packet.
- pkt_count  out  CNT_WIDTH  packets completed.
- err_count  out  CNT_WIDTH  packets with at least one error.
- flow_pkt_count  out  FLOW_NUM*CNT_WIDTH  packets completed per valid flow. Flow f occupies bits [f*CNT_WIDTH +: CNT_WIDTH].
- last_err_code  out  3  code of the most recent erroneous packet.
- err_flag  out  1  sticky. Set by any error, cleared only by rst.
- interval_bytes  out  CNT_WIDTH  bytes accepted in the last completed interval.
- interval_valid  out  1  one-cycle pulse when interval_bytes updates.

## Operation
- A beat is accepted when s_axis_tvalid && s_axis_tready.
- States:
  - HEAD: the next accepted beat is the header.
  - BODY: accepting payload beats.
  - DRAIN: the packet is over-length; beats are absorbed until tlast.
- Beat index: idx = 0 on the header beat and increments on each accepted beat. It saturates at PKT_BEATS.
- Header beat (HEAD):
  - Latch fid = tdata[FLOW_ID_BYTE*8 +: 8].
  - fid >= FLOW_NUM raises FLOW.
  - tlast on the header beat raises LEN; the state stays in HEAD and the packet is closed.
  - Otherwise the state goes to BODY.
- Payload word: w = tdata[63:0].
- idx == 1:
  - Latch base = w - 1 (64-bit arithmetic, wraps).
  - If the flow is valid and seen_flag[fid] is set, require base > last_base[fid], else SEQ.
- idx in 2..PKT_BEATS-1: require w == base + idx, else DATA.
- Every accepted beat requires tkeep all ones, else KEEP.
- Length rules:
  - tlast at idx < PKT_BEATS-1 raises LEN.
  - No tlast at idx == PKT_BEATS-1 raises LEN and the state goes to DRAIN.
  - In DRAIN, tlast returns the state to HEAD.
- Error codes: 0 none, 1 LEN, 2 KEEP, 3 FLOW, 4 SEQ, 5 DATA.
  - Same-beat priority is LEN > KEEP > FLOW > SEQ > DATA.
  - Within a packet, the first error detected is kept as pkt_err.
- Packet close, on the tlast beat:
  - pkt_count++.
  - If fid is valid: flow_pkt_count[fid]++, last_base[fid] <= base, seen_flag[fid] <= 1.
  - If pkt_err != 0: err_count++, last_err_code <= pkt_err, err_flag <= 1.
  - A packet closed before idx 1 (header with tlast) does not update last_base or seen_flag.
- Throughput: cyc counts every cycle out of reset, 0..INTERVAL-1, and wraps. acc += popcount(tkeep) on each accepted beat.
- When cyc == INTERVAL-1:
  - interval_bytes <= acc + this cycle's beat bytes.
  - acc <= 0.
  - interval_valid is high the following cycle.
- All counters wrap modulo 2^CNT_WIDTH.

## Timing
- Reset values:
  - All outputs are 0: s_axis_tready=0, counters 0, last_err_code 0, err_flag 0, interval_bytes 0, interval_valid 0.
  - Internal: state HEAD, seen_flag all 0, cyc 0.
- A reset mid-packet discards the packet and does not count it.
- Statistics update on the cycle after the tlast handshake; latency is 1.
- s_axis_tready never deasserts after reset, so there is no backpressure and every beat is accepted.
- A tvalid gap mid-packet is allowed: idx and state hold.
- When the tlast beat and the interval wrap fall on the same cycle, both complete.
  - The beat's bytes go to the closing interval.
  - The new acc starts at 0.
- The first interval_valid pulse occurs at cycle INTERVAL after rst deasserts.

## Test plan
- **Good stream.** Stimulus: 10 packets of 23 full beats; flows 0,1,2,0,1,1,0,1,2,1; beat k of packet n carries k+n. Required: pkt_count=10; flow_pkt_count = {0:3, 1:5, 2:2}; err_count=0; err_flag=0.
- **Short and long packets.** Stimulus: one packet with tlast at idx 10, then one 25-beat packet. Required: err_count=2; last_err_code=1; the following good packet counts cleanly, confirming DRAIN recovery.
- **Bad content.**
  - Beat idx 5 carries base+6: last_err_code=5.
  - tkeep=0x0FFF... on idx 7: code 2.
  - Flow ID 7: code 3, and flow_pkt_count is unchanged.
  - A packet with the same priority order mixing KEEP and DATA on the same beat reports 2.
- **Sequence.** Stimulus: flow 1 with base 5, then flow 1 with base 3. Required: the second packet raises code 4. A flow 2 packet with base 3 is clean, because the check is per flow.
- **Throughput.** Stimulus: continuous valid beats, full tkeep. Required: interval_valid pulses every 4096 cycles; interval_bytes = 4096*64 = 262144.
- **Reset mid-packet.** Stimulus: assert rst at idx 12. Required: all outputs are 0 in the next cycle; the next header is parsed from HEAD; no SEQ error is raised on the first post-reset packet of each flow.
